// File: rtl/jt10_adpcma_pkg.sv
// jt10_adpcma_pkg: shared constants and types for the ADPCM-A channel scheduler
//   CHANNELS   : number of channel slots (equals decoder pipeline depth)
//   slot_t     : channel/slot index type
//   SEL_*      : cfg_sel encodings
//   fetch_st_t : ROM fetch engine state
package jt10_adpcma_pkg;

    localparam int CHANNELS = 6;

    typedef logic [2:0] slot_t;

    localparam slot_t LAST_SLOT = slot_t'(CHANNELS - 1);

    localparam logic [1:0] SEL_START = 2'd0;
    localparam logic [1:0] SEL_END   = 2'd1;
    localparam logic [1:0] SEL_LOOP  = 2'd2;

    typedef enum logic {F_IDLE, F_REQ} fetch_st_t;

endpackage

// File: rtl/jt10_adpcma_fetch.sv
// jt10_adpcma_fetch: round-robin ROM byte fetcher with generation check
//   need/active/gen/cur : per-channel request state from the scheduler
//   rom_addr/rom_cs     : request held until rom_ok
//   rom_ok/rom_data     : ROM completion and byte
//   wr_en/wr_ch/wr_data : byte to store into the channel buffer (same clk as rom_ok)
module jt10_adpcma_fetch
    import jt10_adpcma_pkg::*;
#(
    parameter int AW = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS-1:0]          need,
    input  logic [CHANNELS-1:0]          active,
    input  logic [CHANNELS-1:0]          gen,
    input  logic [CHANNELS-1:0][AW-1:0]  cur,
    output logic [AW-1:0]                rom_addr,
    output logic                         rom_cs,
    input  logic                         rom_ok,
    input  logic [7:0]                   rom_data,
    output logic                         wr_en,
    output slot_t                        wr_ch,
    output logic [7:0]                   wr_data
);

    fetch_st_t      st_q, st_d;
    slot_t          ch_q, ch_d, last_q, last_d, cand, pick;
    logic           gen_q, gen_d, cs_q, cs_d, pick_v;
    logic [AW-1:0]  addr_q, addr_d;

    // Scan starts at the channel after the last one served
    always_comb begin
        pick_v = 1'b0;
        pick   = last_q;
        cand   = last_q;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = (cand == LAST_SLOT) ? '0 : cand + 1'b1;
            if (!pick_v && need[cand]) begin
                pick_v = 1'b1;
                pick   = cand;
            end
        end
    end

    // A byte is kept only if the channel was not keyed off/on again meanwhile
    assign wr_en   = (st_q == F_REQ) && rom_ok && active[ch_q] && (gen[ch_q] == gen_q);
    assign wr_ch   = ch_q;
    assign wr_data = rom_data;

    always_comb begin
        st_d   = st_q;
        ch_d   = ch_q;
        last_d = last_q;
        gen_d  = gen_q;
        addr_d = addr_q;
        cs_d   = cs_q;
        if (st_q == F_IDLE) begin
            if (pick_v) begin
                st_d   = F_REQ;
                ch_d   = pick;
                last_d = pick;
                gen_d  = gen[pick];
                addr_d = cur[pick];
                cs_d   = 1'b1;
            end
        end else if (rom_ok) begin
            st_d   = F_IDLE;
            cs_d   = 1'b0;
            addr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= F_IDLE;
            ch_q   <= '0;
            last_q <= LAST_SLOT;
            gen_q  <= 1'b0;
            addr_q <= '0;
            cs_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            ch_q   <= ch_d;
            last_q <= last_d;
            gen_q  <= gen_d;
            addr_q <= addr_d;
            cs_q   <= cs_d;
        end
    end

    assign rom_addr = addr_q;
    assign rom_cs   = cs_q;

endmodule

// File: rtl/jt10_adpcma_sched.sv
// jt10_adpcma_sched: sequences six ADPCM-A channels through the shared decoder
//   cen                   : one channel slot per enable
//   cfg_we/ch/sel/data    : start/end page (and loop bit) writes
//   keyon/keyoff/flag_clr : per-channel control pulses
//   rom_addr/cs/ok/data   : shared ROM fetch port
//   data/chon/clr/slot    : registered decoder stage-I inputs
//   flag                  : sticky end-of-sample flags
// Optional: JT10_ADPCMA_LOOP_EN adds a per-channel loop bit (cfg_sel=2).
module jt10_adpcma_sched
    import jt10_adpcma_pkg::*;
#(
    parameter int AW = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_ch,
    input  logic [1:0]           cfg_sel,
    input  logic [15:0]          cfg_data,
    input  logic [CHANNELS-1:0]  keyon,
    input  logic [CHANNELS-1:0]  keyoff,
    input  logic [CHANNELS-1:0]  flag_clr,
    output logic [AW-1:0]        rom_addr,
    output logic                 rom_cs,
    input  logic                 rom_ok,
    input  logic [7:0]           rom_data,
    output logic [3:0]           data,
    output logic                 chon,
    output logic                 clr,
    output logic [2:0]           slot,
    output logic [CHANNELS-1:0]  flag
);

    logic [CHANNELS-1:0][AW-9:0] start_q, start_d, end_q, end_d;
    logic [CHANNELS-1:0][AW-1:0] cur_q, cur_d;
    logic [CHANNELS-1:0][7:0]    buf_q, buf_d;
    logic [CHANNELS-1:0]         buf_v_q, buf_v_d, nib_hi_q, nib_hi_d, active_q, active_d;
    logic [CHANNELS-1:0]         gen_q, gen_d, pend_on_q, pend_on_d, pend_off_q, pend_off_d;
    logic [CHANNELS-1:0]         flag_q, flag_d, need;
`ifdef JT10_ADPCMA_LOOP_EN
    logic [CHANNELS-1:0]         loop_q, loop_d;
`endif
    slot_t                       cnt_q, cnt_d, slot_q, slot_d;
    logic [3:0]                  data_q, data_d;
    logic                        chon_q, chon_d, clr_q, clr_d;
    logic                        wr_en;
    slot_t                       wr_ch;
    logic [7:0]                  wr_data;

    assign need = active_q & ~buf_v_q;

    jt10_adpcma_fetch #(.AW(AW)) u_fetch (
        .clk      (clk),
        .rst_n    (rst_n),
        .need     (need),
        .active   (active_q),
        .gen      (gen_q),
        .cur      (cur_q),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_ok   (rom_ok),
        .rom_data (rom_data),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_data  (wr_data)
    );

    always_comb begin
        start_d    = start_q;
        end_d      = end_q;
        cur_d      = cur_q;
        buf_d      = buf_q;
        buf_v_d    = buf_v_q;
        nib_hi_d   = nib_hi_q;
        active_d   = active_q;
        gen_d      = gen_q;
        pend_on_d  = pend_on_q | keyon;
        pend_off_d = pend_off_q | keyoff;
        flag_d     = flag_q & ~flag_clr;
`ifdef JT10_ADPCMA_LOOP_EN
        loop_d     = loop_q;
`endif
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        data_d     = data_q;
        chon_d     = chon_q;
        clr_d      = clr_q;
        // Fetch result lands first so a key event in the same clk overrides it
        if (wr_en) begin
            buf_d[wr_ch]   = wr_data;
            buf_v_d[wr_ch] = 1'b1;
        end
        if (cfg_we && cfg_ch <= LAST_SLOT) begin
            if (cfg_sel == SEL_START) start_d[cfg_ch] = cfg_data[AW-9:0];
            if (cfg_sel == SEL_END)   end_d[cfg_ch]   = cfg_data[AW-9:0];
`ifdef JT10_ADPCMA_LOOP_EN
            if (cfg_sel == SEL_LOOP)  loop_d[cfg_ch]  = cfg_data[0];
`endif
        end
        if (cen) begin
            slot_d = cnt_q;
            cnt_d  = (cnt_q == LAST_SLOT) ? '0 : cnt_q + 1'b1;
            data_d = 4'd0;
            chon_d = 1'b0;
            clr_d  = 1'b0;
            if (pend_on_d[cnt_q]) begin
                clr_d                = 1'b1;
                cur_d[cnt_q]         = {start_q[cnt_q], 8'h00};
                nib_hi_d[cnt_q]      = 1'b1;
                buf_v_d[cnt_q]       = 1'b0;
                active_d[cnt_q]      = 1'b1;
                flag_d[cnt_q]        = 1'b0;
                gen_d[cnt_q]         = ~gen_q[cnt_q];
                pend_on_d[cnt_q]     = 1'b0;
                pend_off_d[cnt_q]    = 1'b0;
            end else if (pend_off_d[cnt_q]) begin
                active_d[cnt_q]      = 1'b0;
                buf_v_d[cnt_q]       = 1'b0;
                pend_off_d[cnt_q]    = 1'b0;
            end else if (active_q[cnt_q] && buf_v_q[cnt_q]) begin
                chon_d          = 1'b1;
                data_d          = nib_hi_q[cnt_q] ? buf_q[cnt_q][7:4] : buf_q[cnt_q][3:0];
                nib_hi_d[cnt_q] = ~nib_hi_q[cnt_q];
                if (!nib_hi_q[cnt_q]) begin
                    buf_v_d[cnt_q] = 1'b0;
                    cur_d[cnt_q]   = cur_q[cnt_q] + 1'b1;
                    if (cur_q[cnt_q] == {end_q[cnt_q], 8'hFF}) begin
                        flag_d[cnt_q] = 1'b1;
`ifdef JT10_ADPCMA_LOOP_EN
                        if (loop_q[cnt_q]) cur_d[cnt_q] = {start_q[cnt_q], 8'h00};
                        else active_d[cnt_q] = 1'b0;
`else
                        active_d[cnt_q] = 1'b0;
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= '0;
            end_q      <= '0;
            cur_q      <= '0;
            buf_q      <= '0;
            buf_v_q    <= '0;
            nib_hi_q   <= '0;
            active_q   <= '0;
            gen_q      <= '0;
            pend_on_q  <= '0;
            pend_off_q <= '0;
            flag_q     <= '0;
`ifdef JT10_ADPCMA_LOOP_EN
            loop_q     <= '0;
`endif
            cnt_q      <= '0;
            slot_q     <= '0;
            data_q     <= '0;
            chon_q     <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            start_q    <= start_d;
            end_q      <= end_d;
            cur_q      <= cur_d;
            buf_q      <= buf_d;
            buf_v_q    <= buf_v_d;
            nib_hi_q   <= nib_hi_d;
            active_q   <= active_d;
            gen_q      <= gen_d;
            pend_on_q  <= pend_on_d;
            pend_off_q <= pend_off_d;
            flag_q     <= flag_d;
`ifdef JT10_ADPCMA_LOOP_EN
            loop_q     <= loop_d;
`endif
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            data_q     <= data_d;
            chon_q     <= chon_d;
            clr_q      <= clr_d;
        end
    end

    assign data = data_q;
    assign chon = chon_q;
    assign clr  = clr_q;
    assign slot = slot_q;
    assign flag = flag_q;

endmodule

// File: tb/tb_jt10_adpcma_sched.sv
// tb_jt10_adpcma_sched: scoreboard bench for the ADPCM-A scheduler
module tb_jt10_adpcma_sched;
    import jt10_adpcma_pkg::*;

    localparam int AW = 24;

    logic           clk = 1'b0, rst_n = 1'b0, cen = 1'b0;
    logic           cfg_we = 1'b0;
    logic [2:0]     cfg_ch = '0;
    logic [1:0]     cfg_sel = '0;
    logic [15:0]    cfg_data = '0;
    logic [5:0]     keyon = '0, keyoff = '0, flag_clr = '0;
    logic [AW-1:0]  rom_addr;
    logic           rom_cs;
    logic           rom_ok = 1'b0;
    logic [7:0]     rom_data = '0;
    logic [3:0]     data;
    logic           chon, clr;
    logic [2:0]     slot;
    logic [5:0]     flag;

    int             checks = 0, failures = 0;
    logic [3:0]     exp_q [6][$];
    int             nib_left [6];
    bit             exp_clr [6];
    bit             loop_en [6];
    logic [15:0]    page [6];
    int             exp_slot = 0, wraps = 0, underruns = 0;
    bit             mon_en = 0, mon_cen = 0;
    int             rom_delay = 0, wait_cnt = 0;
    bit             in_req = 0, first_chk = 0;
    int             rr_left = 0, rr_next = 0;

    jt10_adpcma_sched #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .keyon(keyon), .keyoff(keyoff), .flag_clr(flag_clr),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
        .data(data), .chon(chon), .clr(clr), .slot(slot), .flag(flag)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        return (a == 24'h001000) ? 8'hA7 : (a[7:0] ^ a[15:8] ^ 8'h3C);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_run(input int ch, input logic [15:0] pg);
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = rom_byte({pg, 8'(i)});
            exp_q[ch].push_back(b[7:4]);
            exp_q[ch].push_back(b[3:0]);
        end
    endtask

    task automatic cfg(input int ch, input logic [1:0] sel, input logic [15:0] d);
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_sel = sel; cfg_data = d;
        if (sel == SEL_START) page[ch] = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic key(input logic [5:0] on, input logic [5:0] off);
        for (int i = 0; i < 6; i++) begin
            if (on[i]) begin
                exp_q[i].delete(); push_run(i, page[i]); nib_left[i] = 512; exp_clr[i] = 1;
            end else if (off[i]) begin
                exp_q[i].delete(); nib_left[i] = 0;
            end
        end
        keyon = on; keyoff = off;
        @(negedge clk);
        keyon = '0; keyoff = '0;
    endtask

    task automatic pulse_clr(input logic [5:0] m);
        flag_clr = m;
        @(negedge clk);
        flag_clr = '0;
    endtask

    task automatic wait_cs(input logic [7:0] pg, input int budget);
        int n = 0;
        while (!(rom_cs && rom_addr[15:8] == pg) && n < budget) begin @(negedge clk); n++; end
        chk("wait_cs", rom_cs, 1);
    endtask

    task automatic wait_drain(input logic [5:0] m, input int budget);
        int n = 0;
        bit busy = 1;
        while (busy && n < budget) begin
            busy = 0;
            for (int i = 0; i < 6; i++) if (m[i] && exp_q[i].size() != 0) busy = 1;
            if (busy) begin @(negedge clk); n++; end
        end
        for (int i = 0; i < 6; i++) if (m[i]) chk($sformatf("drain_ch%0d", i), exp_q[i].size(), 0);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_rom_cs"}, rom_cs, 0);
        chk({p, "_rom_addr"}, rom_addr, 0);
        chk({p, "_data"}, data, 0);
        chk({p, "_chon"}, chon, 0);
        chk({p, "_clr"}, clr, 0);
        chk({p, "_slot"}, slot, 0);
        chk({p, "_flag"}, flag, 0);
    endtask

    // Output monitor: one sample per cen, indexed by the bench's own slot model
    initial forever begin
        @(posedge clk);
        mon_cen = cen;
        #1;
        if (mon_en && mon_cen) begin
            chk("slot_seq", slot, exp_slot);
            if (exp_clr[exp_slot]) begin
                chk("keyon_clr", clr, 1);
                chk("keyon_chon", chon, 0);
                exp_clr[exp_slot] = 0;
            end else chk("clr_idle", clr, 0);
            if (chon) begin
                if (exp_q[exp_slot].size() == 0) chk("nib_avail", exp_q[exp_slot].size(), 1);
                else begin
                    chk($sformatf("nibble_ch%0d", exp_slot), data, exp_q[exp_slot].pop_front());
                    nib_left[exp_slot]--;
                    if (nib_left[exp_slot] == 0) begin
                        chk("eos_flag", flag[exp_slot], 1);
                        if (loop_en[exp_slot]) begin
                            push_run(exp_slot, page[exp_slot]);
                            nib_left[exp_slot] = 512;
                            wraps++;
                        end
                    end
                end
            end else begin
                chk("idle_data", data, 0);
                if (exp_slot == 2 && exp_q[2].size() != 0 && !clr) underruns++;
            end
            exp_slot = (exp_slot + 1) % 6;
        end
    end

    // ROM model: answers rom_delay clocks after a request appears
    initial forever begin
        @(negedge clk);
        rom_ok = 1'b0;
        if (!rom_cs) begin
            in_req = 0; wait_cnt = 0;
        end else begin
            if (!in_req) begin
                in_req = 1; wait_cnt = 0;
                if (first_chk) begin chk("first_addr", rom_addr, 24'h001000); first_chk = 0; end
                if (rr_left > 0) begin
                    chk("rr_order", rom_addr[15:8] - 8'h40, rr_next);
                    rr_next++; rr_left--;
                end
            end
            if (wait_cnt >= rom_delay) begin
                rom_ok = 1'b1; rom_data = rom_byte(rom_addr);
            end else wait_cnt++;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 6; i++) begin page[i] = '0; nib_left[i] = 0; exp_clr[i] = 0; loop_en[i] = 0; end
        repeat (3) @(negedge clk);
        chk_reset("rst0");
        rst_n = 1'b1; cen = 1'b1; mon_en = 1;

        // ch2: single page, slow ROM so underruns appear between nibbles
        cfg(2, SEL_START, 16'h0010);
        cfg(2, SEL_END, 16'h0010);
        rom_delay = 20; first_chk = 1;
        key(6'h04, 6'h00);
        wait_drain(6'h04, 8000);
        chk("underrun_seen", underruns != 0, 1);
        repeat (20) @(negedge clk);
        chk("flag2_sticky", flag[2], 1);
        pulse_clr(6'h04);
        chk("flag2_clr", flag[2], 0);

        // ch4: keyon+keyoff together, then re-key while the fetch is outstanding
        cfg(4, SEL_START, 16'h0020);
        cfg(4, SEL_END, 16'h0020);
        key(6'h10, 6'h10);
        wait_cs(8'h20, 100);
        cfg(4, SEL_START, 16'h0030);
        cfg(4, SEL_END, 16'h0030);
        key(6'h10, 6'h00);
        repeat (8) @(negedge clk);
        rom_delay = 0;
        wait_drain(6'h10, 8000);
        pulse_clr(6'h3F);
        chk("flag_clr_all", flag, 0);

        // all six channels, ROM answering every 2 clk
`ifndef JT10_ADPCMA_LOOP_EN
        cfg(3, SEL_LOOP, 16'h0001);
`endif
        for (int i = 0; i < 6; i++) begin
            cfg(i, SEL_START, 16'(16'h0040 + i));
            cfg(i, SEL_END, 16'(16'h0040 + i));
        end
        n = 0;
        do begin @(posedge clk); #1; n++; end while (slot != 3'd5 && n < 12);
        chk("align_slot5", slot, 5);
        @(negedge clk);
        rr_next = 0; rr_left = 6;
        key(6'h3F, 6'h00);
        wait_drain(6'h3F, 12000);
        chk("rr_done", rr_left, 0);
        chk("flags_all", flag, 6'h3F);

`ifdef JT10_ADPCMA_LOOP_EN
        cfg(0, SEL_LOOP, 16'h0001);
        cfg(0, SEL_START, 16'h0050);
        cfg(0, SEL_END, 16'h0050);
        loop_en[0] = 1; wraps = 0;
        key(6'h01, 6'h00);
        n = 0;
        while (wraps < 1 && n < 6000) begin @(negedge clk); n++; end
        chk("loop_wrap", wraps, 1);
        repeat (30) @(negedge clk);
        loop_en[0] = 0;
        key(6'h00, 6'h01);
        repeat (20) @(negedge clk);
`endif

        // asynchronous reset in the middle of a ROM request
        rom_delay = 50;
        cfg(1, SEL_START, 16'h0060);
        cfg(1, SEL_END, 16'h0060);
        key(6'h02, 6'h00);
        wait_cs(8'h60, 100);
        #2;
        mon_en = 0;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
